// File: rtl/light_pkg.sv
// Shared definitions for the RGB light sequencer and its monitor.
// Contents:
//   RED/GREEN/BLUE/OFF : raw 3-bit LED codes on the rgb bus
//   color_t            : decoded colour (C_INVALID for any unlisted code)
//   mon_state_t        : state encoding of light_sequence_monitor
//   is_legal_pair()    : true for the only permitted colour successions
package light_pkg;

    localparam logic [2:0] RED   = 3'b001;
    localparam logic [2:0] GREEN = 3'b101;
    localparam logic [2:0] BLUE  = 3'b110;
    localparam logic [2:0] OFF   = 3'b000;

    typedef enum logic [2:0] {
        C_RED     = 3'd0,
        C_GREEN   = 3'd1,
        C_BLUE    = 3'd2,
        C_OFF     = 3'd3,
        C_INVALID = 3'd4
    } color_t;

    typedef enum logic [1:0] {
        S_UNLOCKED = 2'd0,
        S_LOCKED   = 2'd1,
        S_FAULT    = 2'd2
    } mon_state_t;

    // RED->GREEN, GREEN->BLUE and BLUE->RED are the only legal steps.
    function automatic logic is_legal_pair(input color_t prev, input color_t cur);
        return ((prev == C_RED)   && (cur == C_GREEN)) ||
               ((prev == C_GREEN) && (cur == C_BLUE))  ||
               ((prev == C_BLUE)  && (cur == C_RED));
    endfunction

endpackage

// File: rtl/rgb_color_decode.sv
// Combinational decode of a raw rgb LED code into a color_t.
// Ports:
//   rgb   in  [2:0] raw LED code
//   color out       decoded colour, C_INVALID for unlisted codes
module rgb_color_decode
    import light_pkg::*;
(
    input  logic [2:0] rgb,
    output color_t     color
);

    // Map each legal code to its colour; everything else is invalid.
    always_comb begin
        color = C_INVALID;
        case (rgb)
            RED:     color = C_RED;
            GREEN:   color = C_GREEN;
            BLUE:    color = C_BLUE;
            OFF:     color = C_OFF;
            default: color = C_INVALID;
        endcase
    end

endmodule

// File: rtl/light_sequence_monitor.sv
// Observer for the rgb LED bus: checks the RED->GREEN->BLUE->RED cycle,
// counts completed rounds, flags idle stalls and latches the first fault.
// Ports:
//   clk        in   system clock (posedge)
//   rst        in   synchronous active-high reset
//   rgb        in   [2:0] LED code from the sequencer
//   locked     out  synchronised to a legal sequence
//   fault      out  sticky illegal code / illegal transition
//   fault_prev out  [2:0] rgb value before the faulting change
//   fault_next out  [2:0] rgb value that caused the fault
//   rounds     out  [ROUND_W-1:0] completed BLUE->RED steps while locked
//   stalled    out  locked with no change for MAX_DWELL cycles
module light_sequence_monitor
    import light_pkg::*;
#(
    parameter int MAX_DWELL = 1000,
    parameter int ROUND_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         rgb,
    output logic               locked,
    output logic               fault,
    output logic [2:0]         fault_prev,
    output logic [2:0]         fault_next,
    output logic [ROUND_W-1:0] rounds,
    output logic               stalled
);

    localparam int DWELL_W = $clog2(MAX_DWELL + 1);
    localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(MAX_DWELL);

    mon_state_t         state_r, state_n_s;
    logic [2:0]         rgb_q_r;
    logic [DWELL_W-1:0] dwell_r, dwell_n_s;
    logic [ROUND_W-1:0] rounds_r, rounds_n_s;
    logic [2:0]         fault_prev_r, fault_prev_n_s;
    logic [2:0]         fault_next_r, fault_next_n_s;
    logic               locked_r, fault_r, stalled_r;
    color_t             cur_color_s, prev_color_s;
    logic               change_s, legal_s, enter_fault_s;

    rgb_color_decode u_dec_cur  (.rgb(rgb),     .color(cur_color_s));
    rgb_color_decode u_dec_prev (.rgb(rgb_q_r), .color(prev_color_s));

    assign change_s = (rgb != rgb_q_r);
    assign legal_s  = is_legal_pair(prev_color_s, cur_color_s);

    // Next-state, dwell, round and fault-capture decisions for this edge.
    always_comb begin
        state_n_s      = state_r;
        dwell_n_s      = dwell_r;
        rounds_n_s     = rounds_r;
        fault_prev_n_s = fault_prev_r;
        fault_next_n_s = fault_next_r;
        enter_fault_s  = 1'b0;
        case (state_r)
            S_UNLOCKED: begin
                dwell_n_s = {DWELL_W{1'b0}};
                if (cur_color_s == C_INVALID) begin
                    enter_fault_s = 1'b1;
                end else if (change_s && legal_s) begin
                    state_n_s = S_LOCKED;
                end else begin
                    state_n_s = S_UNLOCKED;
                end
            end
            S_LOCKED: begin
                if (change_s) begin
                    dwell_n_s = {DWELL_W{1'b0}};
                    if (legal_s) begin
                        if (prev_color_s == C_BLUE) begin
                            rounds_n_s = rounds_r + ROUND_W'(1);
                        end else begin
                            rounds_n_s = rounds_r;
                        end
                    end else begin
                        enter_fault_s = 1'b1;
                    end
                end else if (dwell_r < DWELL_MAX) begin
                    dwell_n_s = dwell_r + DWELL_W'(1);
                end else begin
                    dwell_n_s = dwell_r;
                end
            end
            S_FAULT: begin
                state_n_s = S_FAULT;
            end
            default: begin
                // Unreachable encoding: treat as a fault so it is visible.
                enter_fault_s = 1'b1;
            end
        endcase
        if (enter_fault_s) begin
            state_n_s      = S_FAULT;
            fault_prev_n_s = rgb_q_r;
            fault_next_n_s = rgb;
        end else begin
            fault_prev_n_s = fault_prev_n_s;
        end
    end

    // State, counters, captures and registered output flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_UNLOCKED;
            rgb_q_r      <= 3'b000;
            dwell_r      <= {DWELL_W{1'b0}};
            rounds_r     <= {ROUND_W{1'b0}};
            fault_prev_r <= 3'b000;
            fault_next_r <= 3'b000;
            locked_r     <= 1'b0;
            fault_r      <= 1'b0;
            stalled_r    <= 1'b0;
        end else begin
            state_r      <= state_n_s;
            rgb_q_r      <= rgb;
            dwell_r      <= dwell_n_s;
            rounds_r     <= rounds_n_s;
            fault_prev_r <= fault_prev_n_s;
            fault_next_r <= fault_next_n_s;
            locked_r     <= (state_n_s == S_LOCKED);
            fault_r      <= (state_n_s == S_FAULT);
            stalled_r    <= (state_n_s == S_LOCKED) && (dwell_n_s == DWELL_MAX);
        end
    end

    assign locked     = locked_r;
    assign fault      = fault_r;
    assign fault_prev = fault_prev_r;
    assign fault_next = fault_next_r;
    assign rounds     = rounds_r;
    assign stalled    = stalled_r;

endmodule

// File: tb/tb_light_sequence_monitor.sv
module tb_light_sequence_monitor;

    localparam int MAXD = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] rgb = 3'b000;

    logic       locked, fault, stalled;
    logic [2:0] fault_prev, fault_next;
    logic [7:0] rounds;
    logic       locked_w, fault_w, stalled_w;
    logic [2:0] fault_prev_w, fault_next_w;
    logic [1:0] rounds_w;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    light_sequence_monitor #(.MAX_DWELL(MAXD), .ROUND_W(8)) dut (
        .clk(clk), .rst(rst), .rgb(rgb),
        .locked(locked), .fault(fault), .fault_prev(fault_prev),
        .fault_next(fault_next), .rounds(rounds), .stalled(stalled)
    );

    light_sequence_monitor #(.MAX_DWELL(MAXD), .ROUND_W(2)) dut_w (
        .clk(clk), .rst(rst), .rgb(rgb),
        .locked(locked_w), .fault(fault_w), .fault_prev(fault_prev_w),
        .fault_next(fault_next_w), .rounds(rounds_w), .stalled(stalled_w)
    );

    // ---------------- behavioural model ----------------
    // mode: 0 unlocked, 1 locked, 2 faulted. Stall is derived from the
    // edge index of the last change rather than a saturating counter.
    bit         m_valid = 1'b0;
    int         m_mode = 0;
    logic [2:0] m_prev = 3'b000;
    int         m_rounds = 0;
    logic [2:0] m_fp = 3'b000;
    logic [2:0] m_fn = 3'b000;
    int         m_edge = 0;
    int         m_last_chg = 0;

    function automatic bit legal(input logic [2:0] p, input logic [2:0] c);
        return (p == 3'b001 && c == 3'b101) || (p == 3'b101 && c == 3'b110) ||
               (p == 3'b110 && c == 3'b001);
    endfunction

    function automatic bit valid_code(input logic [2:0] c);
        return (c == 3'b000) || (c == 3'b001) || (c == 3'b101) || (c == 3'b110);
    endfunction

    always @(posedge clk) begin
        m_edge = m_edge + 1;
        if (rst) begin
            m_valid = 1'b1; m_mode = 0; m_prev = 3'b000; m_rounds = 0;
            m_fp = 3'b000; m_fn = 3'b000;
        end else begin
            if (m_mode == 0) begin
                if (!valid_code(rgb)) begin
                    m_mode = 2; m_fp = m_prev; m_fn = rgb;
                end else if (rgb != m_prev && legal(m_prev, rgb)) begin
                    m_mode = 1; m_last_chg = m_edge;
                end
            end else if (m_mode == 1 && rgb != m_prev) begin
                if (legal(m_prev, rgb)) begin
                    if (m_prev == 3'b110) m_rounds = m_rounds + 1;
                    m_last_chg = m_edge;
                end else begin
                    m_mode = 2; m_fp = m_prev; m_fn = rgb;
                end
            end
            m_prev = rgb;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both DUTs against the model.
    always @(posedge clk) begin
        #1;
        if (m_valid) begin
            chk("locked",     {31'd0, locked},  {31'd0, (m_mode == 1)});
            chk("fault",      {31'd0, fault},   {31'd0, (m_mode == 2)});
            chk("fault_prev", {29'd0, fault_prev}, {29'd0, m_fp});
            chk("fault_next", {29'd0, fault_next}, {29'd0, m_fn});
            chk("rounds",     {24'd0, rounds},  32'(m_rounds % 256));
            chk("rounds_w",   {30'd0, rounds_w}, 32'(m_rounds % 4));
            chk("stalled",    {31'd0, stalled},
                {31'd0, (m_mode == 1) && ((m_edge - m_last_chg) >= MAXD)});
            chk("stalled_w",  {31'd0, stalled_w}, {31'd0, stalled});
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic [2:0] v);
        @(negedge clk);
        rgb = v;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        rgb = 3'b000;
        @(posedge clk);
        #2;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_fault",  {31'd0, fault},  32'd0);
        chk("rst_rounds", {24'd0, rounds}, 32'd0);
        chk("rst_stalled", {31'd0, stalled}, 32'd0);

        // Reset and lock
        for (int i = 0; i < 5; i++) step(3'b001);
        chk("pre_lock", {31'd0, locked}, 32'd0);
        step(3'b101);
        chk("lock_locked", {31'd0, locked}, 32'd1);
        chk("lock_rounds", {24'd0, rounds}, 32'd0);
        chk("lock_fault",  {31'd0, fault},  32'd0);

        // Round counting: three rounds, then two more (wrap on ROUND_W=2)
        step(3'b110); step(3'b001);
        for (int r = 0; r < 2; r++) begin
            step(3'b101); step(3'b110); step(3'b001);
        end
        chk("rounds3",   {24'd0, rounds},   32'd3);
        chk("rounds3_w", {30'd0, rounds_w}, 32'd3);
        for (int r = 0; r < 2; r++) begin
            step(3'b101); step(3'b110); step(3'b001);
        end
        chk("rounds5",   {24'd0, rounds},   32'd5);
        chk("rounds5_w", {30'd0, rounds_w}, 32'd1);

        // Stall: hold BLUE; stalled exactly MAXD edges after the change
        step(3'b101); step(3'b110);
        for (int i = 0; i < MAXD - 1; i++) step(3'b110);
        chk("stall_early", {31'd0, stalled}, 32'd0);
        step(3'b110);
        chk("stall_hit", {31'd0, stalled}, 32'd1);
        step(3'b110);
        chk("stall_hold", {31'd0, stalled}, 32'd1);
        step(3'b001);
        chk("stall_clear", {31'd0, stalled}, 32'd0);
        chk("stall_rounds", {24'd0, rounds}, 32'd6);

        // Illegal transition GREEN -> RED
        step(3'b101);
        step(3'b001);
        chk("ill_fault",  {31'd0, fault},  32'd1);
        chk("ill_locked", {31'd0, locked}, 32'd0);
        chk("ill_prev",   {29'd0, fault_prev}, 32'h5);
        chk("ill_next",   {29'd0, fault_next}, 32'h1);
        step(3'b101); step(3'b110); step(3'b001);
        chk("ill_sticky", {31'd0, fault}, 32'd1);
        chk("ill_rounds", {24'd0, rounds}, 32'd6);
        chk("ill_prev2",  {29'd0, fault_prev}, 32'h5);
        chk("ill_next2",  {29'd0, fault_next}, 32'h1);

        // Invalid code while unlocked
        do_reset();
        step(3'b111);
        chk("inv_fault", {31'd0, fault}, 32'd1);
        chk("inv_next",  {29'd0, fault_next}, 32'h7);
        chk("inv_prev",  {29'd0, fault_prev}, 32'h0);

        // OFF while locked in BLUE
        do_reset();
        step(3'b001); step(3'b101); step(3'b110);
        step(3'b000);
        chk("off_fault", {31'd0, fault}, 32'd1);
        chk("off_prev",  {29'd0, fault_prev}, 32'h6);
        chk("off_next",  {29'd0, fault_next}, 32'h0);

        // Reset coinciding with BLUE -> RED
        do_reset();
        step(3'b001); step(3'b101); step(3'b110);
        @(negedge clk);
        rgb = 3'b001;
        rst = 1'b1;
        @(posedge clk);
        #2;
        chk("mrst_locked", {31'd0, locked}, 32'd0);
        chk("mrst_fault",  {31'd0, fault},  32'd0);
        chk("mrst_rounds", {24'd0, rounds}, 32'd0);
        chk("mrst_prev",   {29'd0, fault_prev}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        rgb = 3'b000;
        step(3'b001);
        chk("post_rst_nofault", {31'd0, fault}, 32'd0);
        step(3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/light_sequence_monitor.md
# light_sequence_monitor

Observer for the three-wire `rgb` LED bus driven by the light sequencer. It samples `rgb` every clock, decodes it to a colour, and checks that every change follows the legal cycle RED→GREEN→BLUE→RED. It reports lock, completed rounds, idle stalls and a sticky fault with the offending transition captured. It sits beside the sequencer on the FPGA top level, or in benches, as the receiving end of the `rgb` interface.

## Interface
- `MAX_DWELL`, 1000: saturation value of the dwell counter, in clock cycles; `stalled` asserts at this value.
- `ROUND_W`, 8: width of the round counter.
- `clk` input 1: single system clock; all logic is on posedge.
- `rst` input 1: synchronous, active-high reset.
- `rgb` input 3: LED code from the sequencer; synchronous to `clk`.
- `locked` output 1: monitor is synchronised to a legal sequence.
- `fault` output 1: sticky illegal-code or illegal-transition flag.
- `fault_prev` output 3: `rgb` value before the faulting change.
- `fault_next` output 3: `rgb` value that caused the fault.
- `rounds` output ROUND_W: count of completed BLUE→RED transitions while locked.
- `stalled` output 1: locked and no `rgb` change for `MAX_DWELL` cycles.

## Operation
- Colour codes:
  - RED = 3'b001
  - GREEN = 3'b101
  - BLUE = 3'b110
  - OFF = 3'b000
  - every other code is INVALID.
- `rgb_q` register holds the previous sample.
- `change` = (`rgb` != `rgb_q`).
- Legal successor pairs are exactly RED→GREEN, GREEN→BLUE and BLUE→RED.
- States:
  - **S_UNLOCKED** (reset state):
    - INVALID `rgb` → S_FAULT.
    - A `change` forming a legal pair → S_LOCKED. This lock transition does not increment `rounds`.
    - Other changes (OFF↔colour, illegal colour pair) → stay.
  - **S_LOCKED**:
    - A `change` forming a legal pair → stay. BLUE→RED increments `rounds`, which wraps modulo 2^ROUND_W.
    - Any other `change`, including to OFF or INVALID → S_FAULT.
  - **S_FAULT**:
    - Terminal until `rst`.
    - On entry, capture `fault_prev` = `rgb_q` and `fault_next` = `rgb`.
    - `rounds`, dwell counter and captures are frozen.
- Dwell counter (width $clog2(MAX_DWELL+1)):
  - Cleared on any `change`.
  - Increments while in S_LOCKED with no change, saturating at MAX_DWELL.
  - Held at 0 in S_UNLOCKED and frozen in S_FAULT.
- Output mapping:
  - `locked` = (state == S_LOCKED).
  - `fault` = (state == S_FAULT).
  - `stalled` = `locked` && dwell == MAX_DWELL.
- Reset values: `rgb_q`=000, state S_UNLOCKED, `locked`=0, `fault`=0, `fault_prev`=000, `fault_next`=000, `rounds`=0, dwell=0, `stalled`=0.
- `rst` asserted mid-operation overrides every transition on that edge, including a simultaneous fault or round increment.

## Timing
- `rgb` is sampled at posedge k, and all decisions are made on that edge.
- Every output reflects edge k starting right after edge k, so latency is 1 cycle from an `rgb` change to a `locked`/`fault`/`rounds` update.
- `rgb_q` updates on every non-reset edge, including in S_FAULT.
- Stall timing: the dwell count reaches MAX_DWELL, and `stalled` asserts, exactly MAX_DWELL edges after the last change while locked.
- When a change and saturation occur on the same edge, the change wins: dwell goes to 0 and `stalled` deasserts.
- First edge after reset: `rgb_q`=000, so the first colour seen is an OFF→colour change and is not a fault.
- All outputs are registered; there are no combinational paths from `rgb` to outputs.

## Structure
- Shared package `light_pkg` contains:
  - colour code localparams (RED, GREEN, BLUE, OFF);
  - the `color_t` enum (C_RED, C_GREEN, C_BLUE, C_OFF, C_INVALID);
  - the monitor state enum.
- The sequencer output decode also uses this package.
- One sub-module: `rgb_color_decode`, combinational, `rgb` → `color_t`. It is instantiated twice, for `rgb` and `rgb_q`.
- The FSM, dwell counter and round counter live in `light_sequence_monitor`.

## Test plan
- **Reset and lock:** reset, then `rgb` 001 for 5 cycles, then 101.
  - After the 101 edge: `locked`=1, `rounds`=0, `fault`=0.
- **Round counting:** while locked, drive 001→101→110→001 three times.
  - `rounds`=3.
  - With ROUND_W=2 and 5 rounds: `rounds`=1 (wrap).
- **Illegal transition:** locked in GREEN (101), drive 001.
  - Next edge: `fault`=1, `locked`=0, `fault_prev`=101, `fault_next`=001.
  - Further legal changes leave `fault`, `rounds` and the captures unchanged until `rst`.
- **Invalid code:**
  - While unlocked, drive 111: `fault`=1, `fault_next`=111.
  - While locked in BLUE, drive 000: `fault`=1, `fault_prev`=110.
- **Stall:** MAX_DWELL=10; lock, then hold 110.
  - `stalled` rises exactly 10 edges after the last change.
  - Drive 001: `stalled`=0 on the next edge, and `rounds` increments.
- **Reset mid-operation:** assert `rst` on the same edge as a BLUE→RED change.
  - All outputs take their reset values.
  - `rounds` does not increment.
